// File: rtl/chromosome_evaluator.sv
// Sequential fitness evaluator: applies stored vectors to a phenotype, scores per-bit mismatches,
// logs one record per vector and optionally aborts once the error budget is exceeded.
module chromosome_evaluator #(
    parameter int unsigned IN_BITS          = 8,
    parameter int unsigned OUT_BITS         = 8,
    parameter int unsigned MAX_SEQ          = 128,
    parameter int unsigned CNT_W            = 32,
    parameter int unsigned CYCLES_TO_IGNORE = 5,
    parameter int unsigned ADDR_W           = 15,
    parameter int unsigned IDX_W            = $clog2(MAX_SEQ)
) (
    input  logic                                  iClock,
    input  logic                                  iReset,
    input  logic                                  iStart,
    input  logic                                  iDoneAck,
    input  logic [IDX_W-1:0]                      iSeqLast,
    input  logic [15:0]                           iCyclesPerInput,
    input  logic [15:0]                           iSampleThreshold,
    input  logic                                  iAbortEnable,
    input  logic [CNT_W-1:0]                      iErrorLimit,
    input  logic                                  iUseHardcoded,
    input  logic [IN_BITS-1:0]                    iHardcodedInput,
    input  logic [MAX_SEQ*IN_BITS-1:0]            iInputSequence,
    input  logic [MAX_SEQ*OUT_BITS-1:0]           iExpected,
    input  logic [MAX_SEQ*OUT_BITS-1:0]           iValid,
    input  logic [OUT_BITS-1:0]                   iChromOutput,
    output logic [IN_BITS-1:0]                    oChromInput,
    output logic                                  oZeroChrom,
    output logic                                  oReady,
    output logic                                  oDone,
    output logic                                  oAborted,
    output logic [2:0]                            oState,
    output logic [OUT_BITS*CNT_W-1:0]             oErrorSums,
    output logic [CNT_W-1:0]                      oTotalErrors,
    output logic                                  oLogWrite,
    output logic [ADDR_W-1:0]                     oLogAddr,
    output logic [IN_BITS+IDX_W+2*OUT_BITS-1:0]   oLogData
);
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ZEROING    = 3'd1,
        INPUT_WAIT = 3'd2,
        PROCESSING = 3'd3,
        DONE       = 3'd4
    } state_t;

    localparam logic [15:0]      MIN_N   = 16'(CYCLES_TO_IGNORE + 1);
    localparam logic [15:0]      IGNORE  = 16'(CYCLES_TO_IGNORE);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(MAX_SEQ - 1);

    state_t                    state, stateNext;
    logic [IDX_W-1:0]          seqLast, index;
    logic [15:0]               cyclesN, threshold, cycle;
    logic [CNT_W-1:0]          errorLimit, totalErrors, totalNext;
    logic                      abortEn, useHard, aborted;
    logic [IN_BITS-1:0]        hardInput, chromInput;
    logic [OUT_BITS*16-1:0]    samplesReg, samplesNext;
    logic [OUT_BITS*CNT_W-1:0] sumsReg, sumsNext;
    logic [ADDR_W-1:0]         logAddr;
    logic [OUT_BITS-1:0]       expVec, validVec, mask;
    logic [CNT_W:0]            totalSum;
    logic [15:0]               sampleCur;
    logic [CNT_W-1:0]          sumCur;
    logic [31:0]               inBase, outBase;
    logic                      lastCycle, sampleActive, abortHit;

    assign outBase      = 32'(index) * OUT_BITS;
    assign inBase       = 32'(index) * IN_BITS;
    assign expVec       = iExpected[outBase +: OUT_BITS];
    assign validVec     = iValid[outBase +: OUT_BITS];
    assign lastCycle    = (state == PROCESSING) && (cycle == cyclesN - 16'd1);
    assign sampleActive = (state == PROCESSING) && (cycle >= IGNORE);
    assign abortHit     = abortEn && (totalNext > errorLimit);

    // The closing cycle's sample feeds the mask, sums and log record in the same cycle.
    always_comb begin
        samplesNext = samplesReg;
        sumsNext    = sumsReg;
        mask        = '0;
        totalSum    = {1'b0, totalErrors};
        sampleCur   = '0;
        sumCur      = '0;
        for (int unsigned b = 0; b < OUT_BITS; b++) begin
            sampleCur = samplesReg[b*16 +: 16];
            if (sampleActive && ((iChromOutput[b] ^ expVec[b]) & validVec[b]) && (sampleCur != 16'hFFFF))
                sampleCur = sampleCur + 16'd1;
            samplesNext[b*16 +: 16] = sampleCur;
            mask[b] = sampleCur > threshold;
            sumCur  = sumsReg[b*CNT_W +: CNT_W];
            if (mask[b] && (sumCur != '1))
                sumCur = sumCur + CNT_W'(1);
            sumsNext[b*CNT_W +: CNT_W] = sumCur;
            totalSum = totalSum + {{CNT_W{1'b0}}, mask[b]};
        end
        totalNext = totalSum[CNT_W] ? '1 : totalSum[CNT_W-1:0];
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:       if (iStart) stateNext = ZEROING;
            ZEROING:    stateNext = INPUT_WAIT;
            INPUT_WAIT: stateNext = PROCESSING;
            PROCESSING: if (lastCycle) begin
                if (abortHit || (index == seqLast)) stateNext = DONE;
                else                                stateNext = INPUT_WAIT;
            end
            DONE:       if (iDoneAck) stateNext = IDLE;
            default:    stateNext = IDLE;
        endcase
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            seqLast     <= '0;
            cyclesN     <= '0;
            threshold   <= '0;
            errorLimit  <= '0;
            abortEn     <= 1'b0;
            useHard     <= 1'b0;
            hardInput   <= '0;
            index       <= '0;
            cycle       <= '0;
            samplesReg  <= '0;
            sumsReg     <= '0;
            totalErrors <= '0;
            logAddr     <= '0;
            aborted     <= 1'b0;
            chromInput  <= '0;
        end else begin
            case (state)
                IDLE: if (iStart) begin
                    seqLast     <= (iSeqLast > IDX_MAX) ? IDX_MAX : iSeqLast;
                    cyclesN     <= (iCyclesPerInput < MIN_N) ? MIN_N : iCyclesPerInput;
                    threshold   <= iSampleThreshold;
                    errorLimit  <= iErrorLimit;
                    abortEn     <= iAbortEnable;
                    useHard     <= iUseHardcoded;
                    hardInput   <= iHardcodedInput;
                    index       <= '0;
                    sumsReg     <= '0;
                    totalErrors <= '0;
                    logAddr     <= '0;
                    aborted     <= 1'b0;
                end
                INPUT_WAIT: begin
                    chromInput <= useHard ? hardInput : iInputSequence[inBase +: IN_BITS];
                    cycle      <= '0;
                    samplesReg <= '0;
                end
                PROCESSING: begin
                    cycle      <= cycle + 16'd1;
                    samplesReg <= samplesNext;
                    if (lastCycle) begin
                        sumsReg     <= sumsNext;
                        totalErrors <= totalNext;
                        logAddr     <= logAddr + ADDR_W'(1);
                        if (abortHit)              aborted <= 1'b1;
                        else if (index != seqLast) index   <= index + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign oChromInput  = chromInput;
    assign oZeroChrom   = (state == ZEROING);
    assign oReady       = (state == IDLE);
    assign oDone        = (state == DONE);
    assign oAborted     = aborted;
    assign oState       = state;
    assign oErrorSums   = sumsReg;
    assign oTotalErrors = totalErrors;
    assign oLogWrite    = lastCycle;
    assign oLogAddr     = logAddr;
    assign oLogData     = (state == PROCESSING) ? {chromInput, index, expVec, mask} : '0;
endmodule

// File: tb/tb_chromosome_evaluator.sv
// Randomised bench for chromosome_evaluator: a behavioural phenotype plus a per-vector
// scoring model predicts sums, abort, DONE timing and every log record.
module tb_chromosome_evaluator;
    localparam int unsigned IN_BITS  = 8;
    localparam int unsigned OUT_BITS = 8;
    localparam int unsigned MAX_SEQ  = 128;
    localparam int unsigned CNT_W    = 32;
    localparam int unsigned ADDR_W   = 15;
    localparam int unsigned IDX_W    = 7;
    localparam int unsigned LOG_W    = IN_BITS + IDX_W + 2*OUT_BITS;
    localparam int          IGN      = 5;

    logic                        iClock = 1'b0, iReset = 1'b1, iStart = 1'b0, iDoneAck = 1'b0;
    logic [IDX_W-1:0]            iSeqLast = '0;
    logic [15:0]                 iCyclesPerInput = '0, iSampleThreshold = '0;
    logic                        iAbortEnable = 1'b0, iUseHardcoded = 1'b0;
    logic [CNT_W-1:0]            iErrorLimit = '0;
    logic [IN_BITS-1:0]          iHardcodedInput = '0;
    logic [MAX_SEQ*IN_BITS-1:0]  iInputSequence = '0;
    logic [MAX_SEQ*OUT_BITS-1:0] iExpected = '0, iValid = '0;
    logic [OUT_BITS-1:0]         iChromOutput;
    logic [IN_BITS-1:0]          oChromInput;
    logic                        oZeroChrom, oReady, oDone, oAborted, oLogWrite;
    logic [2:0]                  oState;
    logic [OUT_BITS*CNT_W-1:0]   oErrorSums;
    logic [CNT_W-1:0]            oTotalErrors;
    logic [ADDR_W-1:0]           oLogAddr;
    logic [LOG_W-1:0]            oLogData;

    chromosome_evaluator #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .MAX_SEQ(MAX_SEQ),
                           .CNT_W(CNT_W), .CYCLES_TO_IGNORE(IGN), .ADDR_W(ADDR_W)) dut (
        .iClock(iClock), .iReset(iReset), .iStart(iStart), .iDoneAck(iDoneAck),
        .iSeqLast(iSeqLast), .iCyclesPerInput(iCyclesPerInput), .iSampleThreshold(iSampleThreshold),
        .iAbortEnable(iAbortEnable), .iErrorLimit(iErrorLimit), .iUseHardcoded(iUseHardcoded),
        .iHardcodedInput(iHardcodedInput), .iInputSequence(iInputSequence), .iExpected(iExpected),
        .iValid(iValid), .iChromOutput(iChromOutput), .oChromInput(oChromInput),
        .oZeroChrom(oZeroChrom), .oReady(oReady), .oDone(oDone), .oAborted(oAborted),
        .oState(oState), .oErrorSums(oErrorSums), .oTotalErrors(oTotalErrors),
        .oLogWrite(oLogWrite), .oLogAddr(oLogAddr), .oLogData(oLogData));

    always #5 iClock = ~iClock;

    int checks = 0, errors = 0;
    int cyc = 0;
    always @(posedge iClock) cyc <= cyc + 1;

    logic [7:0] seqMem [MAX_SEQ];
    logic [7:0] expMem [MAX_SEQ];
    logic [7:0] validMem [MAX_SEQ];
    logic [7:0] stuckMask = '0;
    bit         glitchEn = 1'b0, running = 1'b0, glitchNow;
    int         glitchC = 0, nEffTb = 6, startCyc = 0;

    int                         expSums [OUT_BITS];
    int                         expTotal, expLastK;
    bit                         expAborted;
    logic [7:0]                 lastStim;
    logic [ADDR_W+LOG_W-1:0]    expRecs [$];
    logic [ADDR_W+LOG_W-1:0]    gotRecs [$];

    function automatic logic [7:0] phen(input logic [7:0] x);
        return {x[2:0], x[7:3]} ^ 8'h5A;
    endfunction

    // Glitch position is derived from the start edge and the documented per-vector period.
    always_comb begin
        glitchNow = 1'b0;
        if (glitchEn && running && (cyc - startCyc - 2) >= 0)
            glitchNow = ((cyc - startCyc - 2) % (nEffTb + 1)) == glitchC;
    end
    assign iChromOutput = phen(oChromInput) ^ stuckMask ^ {7'd0, glitchNow};

    always @(negedge iClock) if (oLogWrite) gotRecs.push_back({oLogAddr, oLogData});

    task automatic checkValue(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic setupVectors(input bit randErr, input bit randValid);
        for (int k = 0; k < MAX_SEQ; k++) begin
            seqMem[k]   = 8'($urandom);
            expMem[k]   = phen(seqMem[k]) ^ (randErr ? (8'($urandom) & 8'($urandom)) : 8'h00);
            validMem[k] = randValid ? 8'($urandom) : 8'hFF;
            iInputSequence[k*IN_BITS +: IN_BITS] = seqMem[k];
            iExpected[k*OUT_BITS +: OUT_BITS]    = expMem[k];
            iValid[k*OUT_BITS +: OUT_BITS]       = validMem[k];
        end
    endtask

    task automatic modelRun(input int L, input int nEff, input int thr, input bit abortE,
                            input int limit, input bit useH, input logic [7:0] hard);
        logic [7:0] stim, outv, mask;
        int         cnt;
        logic       o;
        expRecs.delete();
        expTotal = 0; expAborted = 0; expLastK = L;
        for (int b = 0; b < OUT_BITS; b++) expSums[b] = 0;
        for (int k = 0; k <= L; k++) begin
            stim = useH ? hard : seqMem[k];
            outv = phen(stim) ^ stuckMask;
            mask = '0;
            for (int b = 0; b < OUT_BITS; b++) begin
                cnt = 0;
                for (int c = IGN; c < nEff; c++) begin
                    o = outv[b] ^ (glitchEn && b == 0 && c == glitchC);
                    if ((o ^ expMem[k][b]) && validMem[k][b]) cnt++;
                end
                if (cnt > thr) begin
                    mask[b] = 1'b1;
                    expSums[b]++;
                    expTotal++;
                end
            end
            expRecs.push_back({ADDR_W'(k), stim, IDX_W'(k), expMem[k], mask});
            lastStim = stim;
            if (abortE && expTotal > limit) begin
                expAborted = 1'b1;
                expLastK   = k;
                break;
            end
        end
    endtask

    task automatic runEval(input int L, input int nIn, input int thr, input bit abortE, input int limit,
                           input bit useH, input logic [7:0] hard, input bit holdStart, input int resetAt);
        int nEff, budget, doneCyc;
        bit seenDone;
        nEff = (nIn < IGN + 1) ? IGN + 1 : nIn;
        modelRun(L, nEff, thr, abortE, limit, useH, hard);
        iSeqLast = IDX_W'(L); iCyclesPerInput = 16'(nIn); iSampleThreshold = 16'(thr);
        iAbortEnable = abortE; iErrorLimit = CNT_W'(limit);
        iUseHardcoded = useH; iHardcodedInput = hard;
        nEffTb = nEff;
        gotRecs.delete();
        iStart = 1'b1;
        @(posedge iClock); #1;
        startCyc = cyc; running = 1'b1;
        if (!holdStart) iStart = 1'b0;
        checkValue("zeroState", oState, 1);
        checkValue("zeroFlag", oZeroChrom, 1);
        checkValue("startClearsSums", oTotalErrors, 0);
        @(posedge iClock); #1;
        checkValue("waitState", oState, 2);
        checkValue("zeroOnce", oZeroChrom, 0);
        if (resetAt >= 0) begin
            repeat (resetAt*(nEff+1) + 4) @(posedge iClock);
            #3;
            checkValue("preResetState", oState, 3);
            checkValue("preResetAddr", oLogAddr, resetAt);
            iReset = 1'b1;
            #1;
            checkValue("rstState", oState, 0);
            checkValue("rstReady", oReady, 1);
            checkValue("rstSums", oErrorSums[63:0] | oErrorSums[255:64], 0);
            checkValue("rstTotal", oTotalErrors, 0);
            checkValue("rstAddr", oLogAddr, 0);
            checkValue("rstStim", oChromInput, 0);
            checkValue("rstWrite", oLogWrite, 0);
            checkValue("rstData", oLogData, 0);
            #2;
            iReset = 1'b0;
            running = 1'b0;
            iStart = 1'b0;
            @(posedge iClock); #1;
        end else begin
            budget = (L + 1) * (nEff + 1) + 20;
            seenDone = 1'b0;
            doneCyc = -1;
            for (int i = 0; i < budget && !seenDone; i++) begin
                @(posedge iClock); #1;
                if (oState == 3'd3 && holdStart) checkValue("startIgnored", oReady, 0);
                if (oDone) begin
                    seenDone = 1'b1;
                    doneCyc  = cyc;
                end
            end
            iStart = 1'b0;
            checkValue("doneReached", seenDone, 1);
            checkValue("doneCycle", doneCyc - startCyc, 1 + (expLastK + 1) * (nEff + 1));
            checkValue("aborted", oAborted, expAborted);
            checkValue("total", oTotalErrors, expTotal);
            for (int b = 0; b < OUT_BITS; b++)
                checkValue($sformatf("sum%0d", b), oErrorSums[b*CNT_W +: CNT_W], expSums[b]);
            checkValue("stimHold", oChromInput, lastStim);
            checkValue("logCount", gotRecs.size(), expRecs.size());
            for (int i = 0; i < expRecs.size() && i < gotRecs.size(); i++)
                checkValue($sformatf("logRec%0d", i), gotRecs[i], expRecs[i]);
            @(posedge iClock); #1;
            checkValue("doneHolds", oState, 4);
            iDoneAck = 1'b1;
            @(posedge iClock); #1;
            iDoneAck = 1'b0;
            checkValue("ackToIdle", oState, 0);
            checkValue("idleKeepsTotal", oTotalErrors, expTotal);
            running = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        checkValue("resetState", oState, 0);
        checkValue("resetReady", oReady, 1);
        checkValue("resetDone", oDone, 0);
        checkValue("resetTotal", oTotalErrors, 0);
        checkValue("resetAddr", oLogAddr, 0);
        checkValue("resetStim", oChromInput, 0);
        @(negedge iClock) iReset = 1'b0;
        @(posedge iClock); #1;

        setupVectors(1'b0, 1'b0);
        stuckMask = 8'h00; glitchEn = 1'b0;
        runEval(3, 100, 0, 1'b0, 0, 1'b0, 8'h00, 1'b0, -1);

        stuckMask = 8'h04;
        runEval(9, 12, 0, 1'b0, 0, 1'b0, 8'h00, 1'b0, -1);

        stuckMask = 8'h00; glitchEn = 1'b1; glitchC = 8;
        runEval(5, 12, 1, 1'b0, 0, 1'b0, 8'h00, 1'b0, -1);
        glitchC = 11;
        runEval(5, 12, 0, 1'b0, 0, 1'b0, 8'h00, 1'b0, -1);
        glitchEn = 1'b0;

        stuckMask = 8'hFF;
        runEval(127, 10, 0, 1'b1, 5, 1'b0, 8'h00, 1'b0, -1);

        stuckMask = 8'($urandom);
        runEval(4, 8, 0, 1'b0, 0, 1'b1, 8'hA5, 1'b1, -1);

        stuckMask = 8'h81;
        runEval(5, 10, 0, 1'b0, 0, 1'b0, 8'h00, 1'b0, 2);
        stuckMask = 8'h10;
        runEval(3, 9, 0, 1'b0, 0, 1'b0, 8'h00, 1'b0, -1);

        for (int r = 0; r < 5; r++) begin
            setupVectors(1'b1, 1'b1);
            stuckMask = 8'($urandom) & 8'($urandom);
            glitchEn  = 1'($urandom);
            glitchC   = $urandom_range(IGN, IGN + 2);
            runEval($urandom_range(0, 15), $urandom_range(0, 20), $urandom_range(0, 3),
                    1'($urandom), $urandom_range(0, 30), 1'b0, 8'h00, 1'b0, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
